// File: rtl/clk_freq_meter_pkg.sv
// Shared definitions for the multi-channel clock frequency meter:
// register addresses, ID constant, CTRL/STATUS bit positions, gate FSM
// states and Gray/binary conversion helpers.
// Optional feature macro: CLK_FREQ_METER_MINMAX_EN (MIN/MAX registers).
package clk_freq_meter_pkg;

  localparam logic [4:0] ADDR_ID     = 5'd0;
  localparam logic [4:0] ADDR_GATE   = 5'd1;
  localparam logic [4:0] ADDR_STATUS = 5'd2;
  localparam logic [4:0] ADDR_CTRL   = 5'd3;
  localparam logic [4:0] ADDR_FREQ0  = 5'd8;
`ifdef CLK_FREQ_METER_MINMAX_EN
  localparam logic [4:0] ADDR_MIN0   = 5'd16;
  localparam logic [4:0] ADDR_MAX0   = 5'd24;
`endif

  localparam logic [31:0] ID_VALUE = 32'h434C_4B46;

  localparam int CTRL_ENABLE_BIT  = 0;
  localparam int CTRL_CLEAR_BIT   = 1;
  localparam int STATUS_VALID_BIT = 0;
  localparam int STATUS_SEQ_LSB   = 8;

  // ARM: settle after reset so base samples real counts; IDLE: disabled;
  // RUN: gate timer counting.
  typedef enum logic [1:0] {
    GATE_ARM  = 2'd0,
    GATE_IDLE = 2'd1,
    GATE_RUN  = 2'd2
  } gate_state_e;

  // Binary to reflected Gray code (callers zero-extend narrower values).
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary; zero upper bits stay zero so narrower values convert cleanly.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int k = 30; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

endpackage

// File: rtl/clk_freq_meter_if.sv
// Avalon-MM register bus between the host (master) and the meter (slave).
interface clk_freq_meter_if;
  logic [4:0]  avs_address;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_write;
  logic [31:0] avs_writedata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/clk_freq_meter_chan.sv
// One measurement channel: free-running Gray counter clocked by the measured
// clock, multi-flop synchronizer into clk, and Gray-to-binary conversion.
// Only one Gray bit changes per measured edge, so any sample is a valid count.
module clk_freq_meter_chan
  import clk_freq_meter_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_meas,
  output logic [CNT_W-1:0] cur_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] gray_q, gray_d;
  logic [CNT_W-1:0] sync_q [SYNC_STAGES];
  logic [CNT_W-1:0] sync_d [SYNC_STAGES];
  logic [CNT_W-1:0] cur_q, cur_d;

  // Next binary count and its Gray encoding in the measured-clock domain.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    gray_d = CNT_W'(bin2gray(32'(cnt_d)));
  end

  // Measured-clock domain counters, cleared asynchronously by reset.
  always_ff @(posedge clk_meas or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= {CNT_W{1'b0}};
      gray_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q  <= cnt_d;
      gray_q <= gray_d;
    end
  end

  // Synchronizer chain shift and binary conversion of the settled Gray value.
  always_comb begin
    sync_d[0] = gray_q;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    cur_d = CNT_W'(gray2bin(32'(sync_q[SYNC_STAGES-1])));
  end

  // System-clock domain synchronizer and registered binary count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= {CNT_W{1'b0}};
      end
      cur_q <= {CNT_W{1'b0}};
    end else begin
      sync_q <= sync_d;
      cur_q  <= cur_d;
    end
  end

  assign cur_o = cur_q;

endmodule

// File: rtl/clk_freq_meter.sv
// Multi-channel clock frequency meter with Avalon-MM register access.
// Each gate of GATE_CYCLES clk cycles produces FREQ[i] = edges seen on
// clk_meas[i]; led_dbg toggles on every completed gate.
// Optional feature macro: CLK_FREQ_METER_MINMAX_EN adds per-channel MIN/MAX.
module clk_freq_meter
  import clk_freq_meter_pkg::*;
#(
  parameter int N_CH        = 8,
  parameter int CNT_W       = 32,
  parameter int GATE_CYCLES = 125000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] clk_meas,
  clk_freq_meter_if.slave avs,
  output logic            led_dbg
);

  localparam int TMR_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
  // Longer than the channel latency so the first base is a live count.
  localparam logic [2:0] ARM_LAST = 3'(SYNC_STAGES + 2);

  logic [CNT_W-1:0] cur_s [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    clk_freq_meter_chan #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .clk_meas (clk_meas[i]),
      .cur_o    (cur_s[i])
    );
  end

  gate_state_e       state_q, state_d;
  logic [2:0]        arm_q, arm_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              enable_q, enable_d;
  logic              valid_q, valid_d;
  logic [7:0]        seq_q, seq_d;
  logic              led_q, led_d;
  logic [31:0]       readdata_q, readdata_d;
  logic [CNT_W-1:0]  freq_q [N_CH];
  logic [CNT_W-1:0]  freq_d [N_CH];
  logic [CNT_W-1:0]  base_q [N_CH];
  logic [CNT_W-1:0]  base_d [N_CH];
`ifdef CLK_FREQ_METER_MINMAX_EN
  logic [CNT_W-1:0]  min_q [N_CH];
  logic [CNT_W-1:0]  min_d [N_CH];
  logic [CNT_W-1:0]  max_q [N_CH];
  logic [CNT_W-1:0]  max_d [N_CH];
`endif

  logic        ctrl_wr_s;
  logic        clear_s;
  logic        gate_done_s;
  logic        update_s;
  logic        rebase_s;
  logic [31:0] rdata_s;
  logic        unused_wdata_s;

  assign unused_wdata_s = ^avs.avs_writedata[31:2];

  // CTRL decode: enable takes the written value, clear is a one-cycle pulse.
  always_comb begin
    ctrl_wr_s = avs.avs_write && (avs.avs_address == ADDR_CTRL);
    clear_s   = ctrl_wr_s && avs.avs_writedata[CTRL_CLEAR_BIT];
    if (ctrl_wr_s) begin
      enable_d = avs.avs_writedata[CTRL_ENABLE_BIT];
    end else begin
      enable_d = enable_q;
    end
    // A disabling write aborts a gate ending in the same cycle.
    gate_done_s = (state_q == GATE_RUN) && (timer_q == TMR_LAST) && enable_d;
    update_s    = gate_done_s && !clear_s;
    // Base follows the live count whenever no gate is open.
    rebase_s    = (state_q != GATE_RUN) || gate_done_s;
  end

  // Gate FSM: post-reset settle, idle while disabled, run the gate timer.
  always_comb begin
    state_d = state_q;
    arm_d   = arm_q;
    timer_d = timer_q;
    case (state_q)
      GATE_ARM: begin
        timer_d = {TMR_W{1'b0}};
        if (arm_q == ARM_LAST) begin
          arm_d   = arm_q;
          state_d = enable_d ? GATE_RUN : GATE_IDLE;
        end else begin
          arm_d   = arm_q + 3'd1;
          state_d = GATE_ARM;
        end
      end
      GATE_IDLE: begin
        timer_d = {TMR_W{1'b0}};
        if (enable_d) begin
          state_d = GATE_RUN;
        end else begin
          state_d = GATE_IDLE;
        end
      end
      GATE_RUN: begin
        if (!enable_d) begin
          state_d = GATE_IDLE;
          timer_d = {TMR_W{1'b0}};
        end else if (timer_q == TMR_LAST) begin
          state_d = GATE_RUN;
          timer_d = {TMR_W{1'b0}};
        end else begin
          state_d = GATE_RUN;
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = GATE_ARM;
        arm_d   = 3'd0;
        timer_d = {TMR_W{1'b0}};
      end
    endcase
  end

  // Result datapath: clear beats a coinciding gate; differences wrap mod 2^CNT_W.
  always_comb begin
    valid_d = valid_q;
    seq_d   = seq_q;
    led_d   = led_q;
    freq_d  = freq_q;
    base_d  = base_q;
`ifdef CLK_FREQ_METER_MINMAX_EN
    min_d   = min_q;
    max_d   = max_q;
`endif
    for (int i = 0; i < N_CH; i++) begin
      base_d[i] = rebase_s ? cur_s[i] : base_q[i];
    end
    if (clear_s) begin
      valid_d = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        freq_d[i] = {CNT_W{1'b0}};
`ifdef CLK_FREQ_METER_MINMAX_EN
        min_d[i]  = {CNT_W{1'b1}};
        max_d[i]  = {CNT_W{1'b0}};
`endif
      end
    end else if (update_s) begin
      valid_d = 1'b1;
      seq_d   = seq_q + 8'd1;
      led_d   = ~led_q;
      for (int i = 0; i < N_CH; i++) begin
        freq_d[i] = cur_s[i] - base_q[i];
`ifdef CLK_FREQ_METER_MINMAX_EN
        min_d[i]  = (freq_d[i] < min_q[i]) ? freq_d[i] : min_q[i];
        max_d[i]  = (freq_d[i] > max_q[i]) ? freq_d[i] : max_q[i];
`endif
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Register read mux; unmapped addresses and absent channels read zero.
  always_comb begin
    rdata_s = 32'h0;
    case (avs.avs_address)
      ADDR_ID:     rdata_s = ID_VALUE;
      ADDR_GATE:   rdata_s = 32'(GATE_CYCLES);
      ADDR_STATUS: begin
        rdata_s[STATUS_VALID_BIT]    = valid_q;
        rdata_s[STATUS_SEQ_LSB +: 8] = seq_q;
      end
      ADDR_CTRL:   rdata_s[CTRL_ENABLE_BIT] = enable_q;
      default:     rdata_s = 32'h0;
    endcase
    for (int i = 0; i < N_CH; i++) begin
      rdata_s = rdata_s |
        ((avs.avs_address == ADDR_FREQ0 + 5'(i)) ? 32'(freq_q[i]) : 32'h0);
`ifdef CLK_FREQ_METER_MINMAX_EN
      rdata_s = rdata_s |
        ((avs.avs_address == ADDR_MIN0 + 5'(i)) ? 32'(min_q[i]) : 32'h0);
      rdata_s = rdata_s |
        ((avs.avs_address == ADDR_MAX0 + 5'(i)) ? 32'(max_q[i]) : 32'h0);
`endif
    end
    readdata_d = avs.avs_read ? rdata_s : readdata_q;
  end

  // State, results and read data registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= GATE_ARM;
      arm_q      <= 3'd0;
      timer_q    <= {TMR_W{1'b0}};
      enable_q   <= 1'b1;
      valid_q    <= 1'b0;
      seq_q      <= 8'd0;
      led_q      <= 1'b0;
      readdata_q <= 32'h0;
      for (int i = 0; i < N_CH; i++) begin
        freq_q[i] <= {CNT_W{1'b0}};
        base_q[i] <= {CNT_W{1'b0}};
`ifdef CLK_FREQ_METER_MINMAX_EN
        min_q[i]  <= {CNT_W{1'b1}};
        max_q[i]  <= {CNT_W{1'b0}};
`endif
      end
    end else begin
      state_q    <= state_d;
      arm_q      <= arm_d;
      timer_q    <= timer_d;
      enable_q   <= enable_d;
      valid_q    <= valid_d;
      seq_q      <= seq_d;
      led_q      <= led_d;
      readdata_q <= readdata_d;
      freq_q     <= freq_d;
      base_q     <= base_d;
`ifdef CLK_FREQ_METER_MINMAX_EN
      min_q      <= min_d;
      max_q      <= max_d;
`endif
    end
  end

  assign avs.avs_readdata = readdata_q;
  assign led_dbg          = led_q;

endmodule

// File: tb/tb_clk_freq_meter.sv
// Directed bench for clk_freq_meter: 1000-cycle gates at 125 MHz, ch0 100 MHz,
// ch1 stopped, ch2 250 MHz; a second 16-bit instance covers counter wrap.
// Build with CLK_FREQ_METER_MINMAX_EN to include the MIN/MAX sweep.
`timescale 1ns/1ps
module tb_clk_freq_meter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic m0 = 1'b0;
  logic m2 = 1'b0;
  real  ch0_half = 5.0;
  logic [7:0] meas_s;
  logic led_dbg;
  logic led_w;

  int total = 0;
  int bad = 0;

  clk_freq_meter_if bus ();
  clk_freq_meter_if bus_w ();

  assign meas_s = {5'b00000, m2, 1'b0, m0};

  clk_freq_meter #(
    .N_CH(8), .CNT_W(32), .GATE_CYCLES(1000), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clk_meas(meas_s), .avs(bus), .led_dbg(led_dbg)
  );

  clk_freq_meter #(
    .N_CH(1), .CNT_W(16), .GATE_CYCLES(1000), .SYNC_STAGES(2)
  ) dut_w (
    .clk(clk), .reset_n(reset_n), .clk_meas(m2), .avs(bus_w), .led_dbg(led_w)
  );

  initial forever #4 clk = ~clk;
  initial begin
    #0.3;
    forever #(ch0_half) m0 = ~m0;
  end
  initial begin
    #0.3;
    forever #2 m2 = ~m2;
  end

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.avs_address = a;
    bus.avs_read = 1'b1;
    @(negedge clk);
    bus.avs_read = 1'b0;
    d = bus.avs_readdata;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.avs_address = a;
    bus.avs_writedata = d;
    bus.avs_write = 1'b1;
    @(negedge clk);
    bus.avs_write = 1'b0;
  endtask

  task automatic rd_w(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_w.avs_address = a;
    bus_w.avs_read = 1'b1;
    @(negedge clk);
    bus_w.avs_read = 1'b0;
    d = bus_w.avs_readdata;
  endtask

  task automatic wait_gate(input int budget, output int waited, output bit ok);
    logic l0;
    l0 = led_dbg;
    waited = 0;
    while (led_dbg === l0 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    ok = (led_dbg !== l0);
  endtask

  task automatic wait_gate_w(input int budget, output bit ok);
    logic l0;
    int waited;
    l0 = led_w;
    waited = 0;
    while (led_w === l0 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    ok = (led_w !== l0);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    bus.avs_address = 5'd0; bus.avs_read = 1'b0;
    bus.avs_write = 1'b0; bus.avs_writedata = 32'h0;
    bus_w.avs_address = 5'd0; bus_w.avs_read = 1'b0;
    bus_w.avs_write = 1'b0; bus_w.avs_writedata = 32'h0;
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (led_dbg !== 1'b0) begin bad++; $display("FAIL reset_led: got %0b want 0", led_dbg); end
    total++; if (bus.avs_readdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %0h want 0", bus.avs_readdata); end
    reset_n = 1'b1;
    rd(5'd2, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_status: got %0h want 0", d); end
    rd(5'd3, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL reset_ctrl: got %0h want 1", d); end
    rd(5'd8, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_freq0: got %0h want 0", d); end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    rd(5'd0, d);
    total++; if (d !== 32'h434C_4B46) begin bad++; $display("FAIL id: got %0h want 434c4b46", d); end
    rd(5'd1, d);
    total++; if (d !== 32'd1000) begin bad++; $display("FAIL gate: got %0d want 1000", d); end
    rd(5'd7, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL addr7: got %0h want 0", d); end
    rd(5'd4, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL addr4: got %0h want 0", d); end
    wr(5'd0, 32'hDEAD_BEEF);
    rd(5'd0, d);
    total++; if (d !== 32'h434C_4B46) begin bad++; $display("FAIL id_ro: got %0h want 434c4b46", d); end
    rd(5'd15, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL freq7_idle: got %0h want 0", d); end
`ifdef CLK_FREQ_METER_MINMAX_EN
    rd(5'd16, d);
    total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL min0_reset: got %0h want ffffffff", d); end
    rd(5'd24, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL max0_reset: got %0h want 0", d); end
`else
    rd(5'd16, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL addr16: got %0h want 0", d); end
    rd(5'd31, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL addr31: got %0h want 0", d); end
`endif
  endtask

  task automatic test_first_gate();
    logic [31:0] d;
    int w;
    bit ok;
    wait_gate(1200, w, ok);
    total++; if (!ok) begin bad++; $display("FAIL first_gate_timeout: got none want toggle"); end
    total++; if (led_dbg !== 1'b1) begin bad++; $display("FAIL first_led: got %0b want 1", led_dbg); end
    rd(5'd2, d);
    total++; if (d !== 32'h0000_0101) begin bad++; $display("FAIL first_status: got %0h want 101", d); end
    rd(5'd8, d);
    total++; if (d < 32'd799 || d > 32'd801) begin bad++; $display("FAIL first_freq0: got %0d want 800+-1", d); end
  endtask

  task automatic test_channels();
    logic [31:0] d;
    int w;
    bit ok;
    for (int g = 0; g < 3; g++) begin
      wait_gate(1100, w, ok);
      total++; if (!ok) begin bad++; $display("FAIL chan_timeout: got none want toggle"); end
      rd(5'd9, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL chan_freq1: got %0d want 0", d); end
      rd(5'd10, d);
      total++; if (d < 32'd1999 || d > 32'd2001) begin bad++; $display("FAIL chan_freq2: got %0d want 2000+-1", d); end
      rd(5'd8, d);
      total++; if (d < 32'd799 || d > 32'd801) begin bad++; $display("FAIL chan_freq0: got %0d want 800+-1", d); end
      rd(5'd2, d);
      total++; if (d !== {16'h0, 8'(g + 2), 8'h01}) begin bad++; $display("FAIL chan_status: got %0h want seq %0d valid", d, g + 2); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int w;
    bit ok;
    wait_gate(1100, w, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_sync_timeout: got none want toggle"); end
    total++; if (led_dbg !== 1'b1) begin bad++; $display("FAIL rmid_led_pre: got %0b want 1", led_dbg); end
    rd(5'd2, d);
    total++; if (d !== 32'h0000_0501) begin bad++; $display("FAIL rmid_status_pre: got %0h want 501", d); end
    rd(5'd0, d);
    repeat (494) @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++; if (bus.avs_readdata !== 32'h0) begin bad++; $display("FAIL rmid_rdata: got %0h want 0", bus.avs_readdata); end
    total++; if (led_dbg !== 1'b0) begin bad++; $display("FAIL rmid_led: got %0b want 0", led_dbg); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rd(5'd8, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rmid_freq0: got %0h want 0", d); end
    rd(5'd2, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rmid_status: got %0h want 0", d); end
    wait_gate(1100, w, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_gate_timeout: got none want toggle"); end
    rd(5'd8, d);
    total++; if (d < 32'd799 || d > 32'd801) begin bad++; $display("FAIL rmid_freq0_after: got %0d want 800+-1", d); end
    rd(5'd10, d);
    total++; if (d < 32'd1999 || d > 32'd2001) begin bad++; $display("FAIL rmid_freq2_after: got %0d want 2000+-1", d); end
    rd(5'd2, d);
    total++; if (d !== 32'h0000_0101) begin bad++; $display("FAIL rmid_status_after: got %0h want 101", d); end
  endtask

  task automatic test_disable();
    logic [31:0] d;
    logic l0;
    int w;
    bit ok;
    wait_gate(1100, w, ok);
    total++; if (!ok) begin bad++; $display("FAIL dis_sync_timeout: got none want toggle"); end
    repeat (300) @(negedge clk);
    wr(5'd3, 32'h0);
    l0 = led_dbg;
    repeat (2000) @(negedge clk);
    total++; if (led_dbg !== l0) begin bad++; $display("FAIL dis_led: got %0b want %0b", led_dbg, l0); end
    rd(5'd2, d);
    total++; if (d !== 32'h0000_0201) begin bad++; $display("FAIL dis_status: got %0h want 201", d); end
    rd(5'd8, d);
    total++; if (d < 32'd799 || d > 32'd801) begin bad++; $display("FAIL dis_freq0_hold: got %0d want 800+-1", d); end
    rd(5'd3, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL dis_ctrl: got %0h want 0", d); end
    wr(5'd3, 32'h1);
    wait_gate(1100, w, ok);
    total++; if (!ok) begin bad++; $display("FAIL en_gate_timeout: got none want toggle"); end
    total++; if (w < 998 || w > 1002) begin bad++; $display("FAIL en_gate_len: got %0d want 1000", w); end
    rd(5'd8, d);
    total++; if (d < 32'd799 || d > 32'd801) begin bad++; $display("FAIL en_freq0: got %0d want 800+-1", d); end
    rd(5'd2, d);
    total++; if (d !== 32'h0000_0301) begin bad++; $display("FAIL en_status: got %0h want 301", d); end
    wr(5'd3, 32'h3);
    rd(5'd2, d);
    total++; if (d !== 32'h0000_0300) begin bad++; $display("FAIL clr_status: got %0h want 300", d); end
    rd(5'd8, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL clr_freq0: got %0h want 0", d); end
    rd(5'd3, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL clr_ctrl: got %0h want 1", d); end
    wait_gate(1100, w, ok);
    total++; if (!ok) begin bad++; $display("FAIL clr_gate_timeout: got none want toggle"); end
    rd(5'd8, d);
    total++; if (d < 32'd799 || d > 32'd801) begin bad++; $display("FAIL clr_freq0_after: got %0d want 800+-1", d); end
    rd(5'd2, d);
    total++; if (d !== 32'h0000_0401) begin bad++; $display("FAIL clr_status_after: got %0h want 401", d); end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    bit ok;
    for (int g = 0; g < 40; g++) begin
      wait_gate_w(1100, ok);
      total++; if (!ok) begin bad++; $display("FAIL wrap_timeout: got none want toggle at gate %0d", g); end
      rd_w(5'd8, d);
      total++; if (d < 32'd1999 || d > 32'd2001) begin bad++; $display("FAIL wrap_freq0: got %0d want 2000+-1 at gate %0d", d, g); end
    end
  endtask

`ifdef CLK_FREQ_METER_MINMAX_EN
  task automatic test_minmax();
    logic [31:0] d;
    int w;
    bit ok;
    wait_gate(1100, w, ok);
    wr(5'd3, 32'h3);
    rd(5'd16, d);
    total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mm_min_clr: got %0h want ffffffff", d); end
    rd(5'd24, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mm_max_clr: got %0h want 0", d); end
    ch0_half = 5.5556;
    for (int g = 0; g < 2; g++) begin
      wait_gate(1100, w, ok);
      total++; if (!ok) begin bad++; $display("FAIL mm_lo_timeout: got none want toggle"); end
    end
    ch0_half = 4.5455;
    for (int g = 0; g < 2; g++) begin
      wait_gate(1100, w, ok);
      total++; if (!ok) begin bad++; $display("FAIL mm_hi_timeout: got none want toggle"); end
    end
    rd(5'd16, d);
    total++; if (d < 32'd718 || d > 32'd722) begin bad++; $display("FAIL mm_min0: got %0d want 720", d); end
    rd(5'd24, d);
    total++; if (d < 32'd878 || d > 32'd882) begin bad++; $display("FAIL mm_max0: got %0d want 880", d); end
    ch0_half = 5.0;
  endtask
`endif

  initial begin
    test_reset();
    test_regs();
    test_first_gate();
    test_channels();
    test_reset_mid();
    test_disable();
    test_wrap();
`ifdef CLK_FREQ_METER_MINMAX_EN
    test_minmax();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
